rom_fetch_sequencer: RTL and testbench
======================================

Name: rom_fetch_sequencer

Overview:
Sits between the 4-bit CPU core and an external byte-wide program memory. Tracks the CPU's 8-phase instruction cycle from `sync`. Captures the three address nibbles and fetches the opcode byte through a req/ready handshake. Drives the opcode nibbles back to the CPU during M1/M2, stalling the core via its `halt` input until the byte is available.

Parameters:
TIMEOUT, 15, max cycles `mem_req` may stay high without `mem_ready` before a fetch is abandoned (1..255)
NOP_OPCODE, 8'h00, byte delivered to the CPU on timeout

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cpu_sync  input  1  from CPU `sync`; high during the A1 clock of each instruction cycle
cpu_data_o  input  4  from CPU `data_o`
cpu_data_en  input  1  from CPU `data_en`
cpu_data_i  output  4  to CPU `data_i`
cpu_halt  output  1  to CPU `halt`
dbg_halt  input  1  external debug halt, OR-ed into `cpu_halt`
ext_data_i  input  4  data from RAM/IO, passed to CPU outside M1/M2
mem_req  output  1  fetch request
mem_addr  output  12  fetch address {A3,A2,A1 nibbles}
mem_ready  input  1  `mem_data` valid this cycle; completes request
mem_data  input  8  opcode byte, [7:4] = OPR, [3:0] = OPA
fetch_timeout  output  1  one-clock pulse when a fetch is abandoned

Behaviour:
- Reset (async, `reset_n` low):
  - phase=A1, addr=0, opbuf=0, buf_valid=0, timer=0.
  - `mem_req`=0, `fetch_timeout`=0, `cpu_halt`=`dbg_halt`, `cpu_data_i`=`ext_data_i`.
- Phase counter, 3 bits: A1,A2,A3,M1,M2,X1,X2,X3.
  - Advances once per clock when `cpu_halt`=0.
  - Holds while `cpu_halt`=1.
  - `cpu_sync`=1 forces the phase to A1 in that clock; the next clock is A2 (resynchronises).
- Address capture: in A1/A2/A3, when not halted, latch `cpu_data_o` into addr[3:0]/[7:4]/[11:8] respectively. `cpu_data_en` is ignored for capture.
- Fetch FSM, states IDLE, REQ, DONE:
  - IDLE→REQ on the A3 clock edge (not halted). buf_valid cleared. `mem_req`=1 from the next clock (M1).
  - `mem_addr` is registered: it is the full captured address while `mem_req`=1.
  - REQ: on the edge where `mem_ready`=1, opbuf←`mem_data`, buf_valid=1, →DONE, `mem_req` drops next clock.
  - REQ: if timer reaches TIMEOUT without `mem_ready`, opbuf←NOP_OPCODE, buf_valid=1, `fetch_timeout` pulses 1 clock, →DONE.
  - DONE→IDLE when the phase leaves M2.
  - `mem_ready` outside REQ is ignored.
- Stall: `cpu_halt` = `dbg_halt` | (phase==M1 & !buf_valid), derived from registers only.
  - Minimum stall is 1 clock, since `mem_ready` is seen in M1 at the earliest.
- Data mux: `cpu_data_i` = opbuf[7:4] in M1, opbuf[3:0] in M2, `ext_data_i` otherwise.
- `dbg_halt` during REQ:
  - The fetch continues and the timer runs.
  - The phase stays frozen.
- `cpu_sync` arriving while in REQ (CPU reset/resync): abort the fetch, `mem_req`→0, state→IDLE, no `fetch_timeout`.
- Timer: saturates; cleared on entry to REQ.

Optional Feature:
Macro LAST_FETCH_CACHE_EN.
- With it: a single tag register holds the last fetched address plus a valid bit (cleared by reset and by a timeout).
- On A3, if the captured address equals the tag, no request is made: buf_valid=1 immediately and the M1 stall is 0 cycles (tight loops such as JUN-to-self run at full speed).
- Without it: every instruction cycle issues a request.

Decomposition:
- Shared package: phase encoding constants (A1..X3), fetch FSM state encoding, NOP_OPCODE default.
- One natural sub-module: `fetch_timer`, the saturating counter with a compare against TIMEOUT.

Test Plan:
- Fetch, no stall:
  - Stimulus: CPU drives 3,2,1 in A1..A3; memory returns `mem_ready` in the first M1 clock with 8'hD5.
  - Response: `mem_addr`=12'h123; `cpu_halt` high for exactly 1 clock; `cpu_data_i`=D in M1, 5 in M2.
- Memory wait of 4 clocks:
  - Response: `cpu_halt` high for 4 clocks in M1; phase frozen; opcode delivered afterwards.
- Timeout (TIMEOUT=15, `mem_ready` never asserted):
  - Response: `fetch_timeout` pulses once; CPU receives 0,0 in M1/M2; `mem_req` drops.
- Reset mid-fetch:
  - Stimulus: assert `reset_n`=0 while in REQ.
  - Response: `mem_req`=0 and `cpu_halt`=`dbg_halt` immediately (asynchronous); next `cpu_sync` starts a clean cycle.
- `dbg_halt` during X2:
  - Response: phase holds; `ext_data_i` passes through; resumes at X3 after release.
- LAST_FETCH_CACHE_EN, two consecutive cycles at 12'h123:
  - Response: second cycle shows no `mem_req` and no `cpu_halt` in M1.

Source files
------------

// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared types and constants for the ROM fetch sequencer: CPU phase encoding,
// fetch FSM states, bus widths and the default NOP opcode.
package rom_fetch_sequencer_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TMR_W  = 8;

  localparam logic [BYTE_W-1:0] NOP_OPCODE_DEF = 8'h00;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

  // Successor phase; X3 wraps back to A1.
  function automatic phase_e phase_next(input phase_e p);
    return phase_e'(3'(p) + 3'd1);
  endfunction

endpackage

// File: rtl/rom_fetch_sequencer_fetch_timer.sv
// Saturating fetch-wait counter with a registered flag that is high in the
// TIMEOUT-th consecutive cycle of an outstanding request.
module rom_fetch_sequencer_fetch_timer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;
  logic             expired_q;

  always_comb begin
    count_d = (count_q == '1) ? count_q : count_q + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else if (clear_i) begin
      count_q   <= '0;
      expired_q <= (LIMIT == '0);
    end else if (run_i) begin
      count_q   <= count_d;
      expired_q <= (count_d >= LIMIT);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Tracks the CPU's 8-phase cycle, fetches each opcode byte over req/ready and
// stalls the core in M1 until it arrives. LAST_FETCH_CACHE_EN adds a last-address hit.
module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int unsigned       TIMEOUT    = 15,
  parameter logic [BYTE_W-1:0] NOP_OPCODE = NOP_OPCODE_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_sync,
  input  logic [NIB_W-1:0]  cpu_data_o,
  input  logic              cpu_data_en,
  output logic [NIB_W-1:0]  cpu_data_i,
  output logic              cpu_halt,
  input  logic              dbg_halt,
  input  logic [NIB_W-1:0]  ext_data_i,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [BYTE_W-1:0] mem_data,
  output logic              fetch_timeout
);

  phase_e            phase_q, phase_d, phase_eff_c;
  fetch_state_e      state_q;
  logic [7:0]        addr_lo_q;
  logic [ADDR_W-1:0] mem_addr_q, fetch_addr_c;
  logic [BYTE_W-1:0] opbuf_q;
  logic              buf_valid_q, mem_req_q, fetch_timeout_q;
  logic              halt_c, adv_c, a3_fire_c, start_c;
  logic              fetch_ok_c, fetch_to_c, cache_hit_c, tmr_expired;
  logic              unused_ok_c;

  // Capture does not depend on the CPU's output enable.
  assign unused_ok_c = cpu_data_en;

  // A sync resynchronises the phase even if the stale M1 stall is still showing.
  always_comb begin
    phase_eff_c  = cpu_sync ? PH_A1 : phase_q;
    halt_c       = dbg_halt | ((phase_q == PH_M1) & ~buf_valid_q);
    adv_c        = cpu_sync ? ~dbg_halt : ~halt_c;
    a3_fire_c    = (phase_eff_c == PH_A3) & adv_c;
    fetch_addr_c = {cpu_data_o, addr_lo_q};
    start_c      = a3_fire_c & (state_q == FS_IDLE) & ~cache_hit_c;
    fetch_ok_c   = (state_q == FS_REQ) & ~cpu_sync & mem_ready;
    fetch_to_c   = (state_q == FS_REQ) & ~cpu_sync & ~mem_ready & tmr_expired;
    phase_d      = adv_c ? phase_next(phase_eff_c) : phase_eff_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_A1;
      addr_lo_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (adv_c && phase_eff_c == PH_A1) addr_lo_q[3:0] <= cpu_data_o;
      if (adv_c && phase_eff_c == PH_A2) addr_lo_q[7:4] <= cpu_data_o;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= FS_IDLE;
      opbuf_q         <= '0;
      buf_valid_q     <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      fetch_timeout_q <= 1'b0;
    end else begin
      fetch_timeout_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (a3_fire_c && cache_hit_c) begin
            buf_valid_q <= 1'b1;
            state_q     <= FS_DONE;
          end else if (a3_fire_c) begin
            buf_valid_q <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= fetch_addr_c;
            state_q     <= FS_REQ;
          end
        end
        FS_REQ: begin
          if (cpu_sync) begin
            mem_req_q <= 1'b0;
            state_q   <= FS_IDLE;
          end else if (fetch_ok_c) begin
            opbuf_q     <= mem_data;
            buf_valid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= FS_DONE;
          end else if (fetch_to_c) begin
            opbuf_q         <= NOP_OPCODE;
            buf_valid_q     <= 1'b1;
            mem_req_q       <= 1'b0;
            fetch_timeout_q <= 1'b1;
            state_q         <= FS_DONE;
          end
        end
        FS_DONE: begin
          if (cpu_sync || (phase_q == PH_M2 && adv_c)) state_q <= FS_IDLE;
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

`ifdef LAST_FETCH_CACHE_EN
  logic [ADDR_W-1:0] tag_q;
  logic              tag_valid_q;

  // opbuf always holds the byte for tag_q while the tag is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else if (fetch_ok_c) begin
      tag_q       <= mem_addr_q;
      tag_valid_q <= 1'b1;
    end else if (fetch_to_c) begin
      tag_valid_q <= 1'b0;
    end
  end

  assign cache_hit_c = tag_valid_q & (tag_q == fetch_addr_c);
`else
  assign cache_hit_c = 1'b0;
`endif

  rom_fetch_sequencer_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear_i   (start_c),
    .run_i     (state_q == FS_REQ),
    .expired_o (tmr_expired)
  );

  always_comb begin
    cpu_data_i = ext_data_i;
    if (phase_q == PH_M1)      cpu_data_i = opbuf_q[7:4];
    else if (phase_q == PH_M2) cpu_data_i = opbuf_q[3:0];
  end

  assign cpu_halt      = halt_c;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign fetch_timeout = fetch_timeout_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: plays the CPU and the program memory, and
// predicts stalls, nibbles and timeouts from a per-instruction transaction model.
module tb_rom_fetch_sequencer;

  localparam int         TIMEOUT = 15;
  localparam logic [7:0] NOP     = 8'h00;
`ifdef LAST_FETCH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, cpu_sync, cpu_data_en, dbg_halt, mem_ready;
  logic [3:0]  cpu_data_o, ext_data_i, cpu_data_i;
  logic [7:0]  mem_data;
  logic        cpu_halt, mem_req, fetch_timeout;
  logic [11:0] mem_addr;

  always #5 clock = ~clock;

  rom_fetch_sequencer #(.TIMEOUT(TIMEOUT), .NOP_OPCODE(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_sync(cpu_sync), .cpu_data_o(cpu_data_o),
    .cpu_data_en(cpu_data_en), .cpu_data_i(cpu_data_i), .cpu_halt(cpu_halt),
    .dbg_halt(dbg_halt), .ext_data_i(ext_data_i), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .fetch_timeout(fetch_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference state: last successfully fetched address/byte and its validity.
  bit          m_tag_valid = 1'b0;
  logic [11:0] m_tag = '0;
  logic [7:0]  m_byte = '0;
  int          to_seen;
  bit          prev_abort = 1'b0;

  task automatic to_negedge();
    @(negedge clock);
    if (fetch_timeout) to_seen++;
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    ext_data_i  = 4'($urandom);
    mem_ready   = 1'($urandom);
    mem_data    = 8'($urandom);
    cpu_data_en = 1'($urandom);
  endtask

  task automatic passive_cycle(input string tag);
    noise();
    to_negedge();
    check(tag, 32'(cpu_data_i), 32'(ext_data_i));
    check({tag, "_halt"}, 32'(cpu_halt), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    to_next();
  endtask

  // mode 0: normal; 1: new sync during M1 wait at cut_at; 2: reset during M1 wait at cut_at.
  task automatic run_instr(input logic [11:0] addr, input logic [7:0] op, input int lat,
                           input bit use_sync, input int dbg_x2, input int mode, input int cut_at);
    bit         hit, h, done;
    int         exp_h, halts, reqs;
    logic [7:0] exp_b;
    hit   = CACHE && m_tag_valid && (m_tag == addr);
    exp_h = hit ? 0 : ((lat < TIMEOUT) ? lat + 1 : TIMEOUT);
    exp_b = hit ? m_byte : ((lat < TIMEOUT) ? op : NOP);
    to_seen = 0;

    cpu_sync   = use_sync;
    cpu_data_o = addr[3:0];
    noise();
    to_negedge();
    if (!prev_abort) begin
      check("a1_data", 32'(cpu_data_i), 32'(ext_data_i));
      check("a1_req", 32'(mem_req), 32'd0);
    end
    prev_abort = 1'b0;
    to_next();
    cpu_sync   = 1'b0;
    cpu_data_o = addr[7:4];
    passive_cycle("a2_data");
    cpu_data_o = addr[11:8];
    passive_cycle("a3_data");

    halts = 0;
    reqs  = 0;
    done  = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      if (mode == 1 && n == cut_at) begin
        check("abort_stall", 32'(halts), 32'(cut_at));
        check("abort_req", 32'(reqs), 32'(cut_at));
        prev_abort = 1'b1;
        return;
      end
      if (mode == 2 && n == cut_at) begin
        check("prerst_stall", 32'(halts), 32'(cut_at));
        #2 reset_n = 1'b0;
        dbg_halt = 1'b1;
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_halt_dbg", 32'(cpu_halt), 32'd1);
        check("rst_timeout", 32'(fetch_timeout), 32'd0);
        dbg_halt   = 1'b0;
        ext_data_i = 4'($urandom);
        #1;
        check("rst_halt", 32'(cpu_halt), 32'd0);
        check("rst_data", 32'(cpu_data_i), 32'(ext_data_i));
        to_next();
        to_next();
        reset_n     = 1'b1;
        m_tag_valid = 1'b0;
        return;
      end
      mem_ready  = (n == lat);
      mem_data   = (n == lat) ? op : 8'($urandom);
      ext_data_i = 4'($urandom);
      to_negedge();
      h = cpu_halt;
      if (mem_req) reqs++;
      if (n == 0 && exp_h > 0) check("m1_addr", 32'(mem_addr), 32'(addr));
      if (!h) begin
        check("m1_nibble", 32'(cpu_data_i), 32'(exp_b[7:4]));
        done = 1'b1;
      end else begin
        halts++;
      end
      to_next();
    end
    mem_ready = 1'b0;
    check("m1_stall", 32'(halts), 32'(exp_h));
    check("m1_req_cycles", 32'(reqs), 32'(exp_h));

    noise();
    to_negedge();
    check("m2_nibble", 32'(cpu_data_i), 32'(exp_b[3:0]));
    check("m2_halt", 32'(cpu_halt), 32'd0);
    to_next();

    passive_cycle("x1_data");
    for (int k = 0; k < dbg_x2; k++) begin
      dbg_halt = 1'b1;
      noise();
      to_negedge();
      check("x2_dbg_halt", 32'(cpu_halt), 32'd1);
      check("x2_dbg_data", 32'(cpu_data_i), 32'(ext_data_i));
      to_next();
    end
    dbg_halt = 1'b0;
    passive_cycle("x2_data");
    passive_cycle("x3_data");

    check("timeout_pulses", 32'(to_seen), 32'(!hit && lat >= TIMEOUT));
    if (!hit) begin
      if (lat < TIMEOUT) begin
        m_tag_valid = 1'b1;
        m_tag       = addr;
        m_byte      = op;
      end else begin
        m_tag_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] addr, last_addr;
    int          lat, r, dbg;
    bit          force_sync;
    reset_n = 1'b0; cpu_sync = 1'b0; cpu_data_o = '0; cpu_data_en = 1'b0;
    dbg_halt = 1'b1; ext_data_i = 4'h9; mem_ready = 1'b0; mem_data = '0;
    #3;
    check("reset_halt_dbg", 32'(cpu_halt), 32'd1);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_timeout", 32'(fetch_timeout), 32'd0);
    check("reset_data", 32'(cpu_data_i), 32'h9);
    check("reset_addr", 32'(mem_addr), 32'd0);
    dbg_halt = 1'b0;
    #1;
    check("reset_halt", 32'(cpu_halt), 32'd0);
    to_next();
    to_next();
    reset_n = 1'b1;

    run_instr(12'h123, 8'hD5, 0, 1'b1, 0, 0, 0);
    run_instr(12'h123, 8'h3A, 3, 1'b0, 0, 0, 0);
    run_instr(12'h456, 8'h7C, 3, 1'b0, 0, 0, 0);
    run_instr(12'h789, 8'hFF, 255, 1'b0, 0, 0, 0);
    run_instr(12'hABC, 8'h96, TIMEOUT - 1, 1'b0, 0, 0, 0);
    run_instr(12'hABD, 8'h69, TIMEOUT, 1'b0, 0, 0, 0);
    run_instr(12'h246, 8'h1E, 1, 1'b0, 3, 0, 0);
    run_instr(12'h135, 8'hC3, 0, 1'b0, 0, 0, 0);
    run_instr(12'h321, 8'h44, 255, 1'b0, 0, 2, 5);
    run_instr(12'h321, 8'h55, 2, 1'b1, 0, 0, 0);
    run_instr(12'h654, 8'h22, 255, 1'b0, 0, 1, 4);
    run_instr(12'h655, 8'h33, 1, 1'b1, 0, 0, 0);

    last_addr  = 12'h655;
    force_sync = 1'b0;
    for (int i = 0; i < 150; i++) begin
      addr = ($urandom_range(0, 2) == 0) ? last_addr : 12'($urandom);
      r    = int'($urandom_range(0, 9));
      lat  = (r < 6) ? int'($urandom_range(0, 4)) : ((r < 8) ? int'($urandom_range(5, 16)) : 255);
      dbg  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 14) == 0) begin
        addr = m_tag ^ 12'h001;
        run_instr(addr, 8'($urandom), 255, force_sync, 0, 1, int'($urandom_range(1, 10)));
        force_sync = 1'b1;
      end else begin
        run_instr(addr, 8'($urandom), lat,
                  force_sync || ($urandom_range(0, 3) == 0), dbg, 0, 0);
        force_sync = 1'b0;
      end
      last_addr = addr;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
